// File: rtl/text_pixel_renderer_if.sv
// Glyph request bundle from the letter-lookup producer to the pixel renderer.
// Signals: class flags (score/title/game over), font ROM address, glyph left edge.
interface text_pixel_renderer_if;
    logic        is_score_all_letters;
    logic        is_zoom;
    logic        is_game_over;
    logic [10:0] score_addr;
    logic [10:0] score_x;

    modport master (
        output is_score_all_letters,
        output is_zoom,
        output is_game_over,
        output score_addr,
        output score_x
    );

    modport slave (
        input is_score_all_letters,
        input is_zoom,
        input is_game_over,
        input score_addr,
        input score_x
    );
endinterface

// File: rtl/text_pixel_renderer.sv
// Two-beat text pixel pipeline: drives the 8x16 font ROM, extracts the glyph bit
// for DrawX and emits text_on/text_class with GAME OVER blink.
// Ports: Clk, Reset_n, pix_en, frame_start, blink_en, DrawX, req (glyph request),
//        font_addr/font_data (ROM), text_on, text_class, blink_phase.
module text_pixel_renderer #(
    parameter int BLINK_FRAMES = 30,
    parameter int PIPE_DEPTH   = 2
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  pix_en,
    input  logic                  frame_start,
    input  logic                  blink_en,
    input  logic [9:0]            DrawX,
    text_pixel_renderer_if.slave  req,
    output logic [10:0]           font_addr,
    input  logic [7:0]            font_data,
    output logic                  text_on,
    output logic [1:0]            text_class,
    output logic                  blink_phase
);

    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    if (PIPE_DEPTH != 2) begin : g_depth_fixed
        $error("PIPE_DEPTH is fixed at 2");
    end
    if (BLINK_FRAMES < 1) begin : g_blink_min
        $error("BLINK_FRAMES must be >= 1");
    end

    logic [9:0]    col;
    logic          in_cell;
    logic [1:0]    cls;
    logic [2:0]    col1;
    logic [1:0]    cls1;
    logic          bit_sel;
    logic          on_nxt;
    logic [CW-1:0] frame_cnt;
    logic          unused_score_x_msb;

    assign unused_score_x_msb = req.score_x[10];

    // Wraps modulo 1024, so a pixel left of the cell lands far above 7.
    assign col     = DrawX - req.score_x[9:0];
    assign in_cell = (col[9:3] == 7'd0);

    always_comb begin
        cls = 2'd0;
        if (req.is_score_all_letters) cls = 2'd1;
        else if (req.is_zoom)         cls = 2'd2;
        else if (req.is_game_over)    cls = 2'd3;
        if (!in_cell) cls = 2'd0;
    end

    // Bit 7 is the leftmost pixel, so 7-col1 is simply ~col1.
    assign bit_sel = font_data[~col1];
    assign on_nxt  = (cls1 != 2'd0) & bit_sel
                   & ~((cls1 == 2'd3) & blink_en & blink_phase);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            font_addr  <= '0;
            col1       <= '0;
            cls1       <= '0;
            text_on    <= 1'b0;
            text_class <= '0;
        end else if (pix_en) begin
            font_addr  <= req.score_addr;
            col1       <= col[2:0];
            cls1       <= cls;
            text_on    <= on_nxt;
            text_class <= on_nxt ? cls1 : 2'd0;
        end
    end

    // Stage 2 above samples blink_phase before this block's toggle lands.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt == CW'(BLINK_FRAMES - 1)) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule
